// File: rtl/iter_shifter_if.sv
// Valid/ready request and result channel for the iterative shift unit.
interface iter_shifter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic [CNT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;

  // Producer/consumer side: issues requests, takes results.
  modport master (
    output in_valid, in_data, in_op, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  // Shift unit side.
  modport slave (
    input  in_valid, in_data, in_op, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );
endinterface

// File: rtl/iter_shifter.sv
// Iterative shift unit: applies a one-bit shift/rotate step once per clock,
// amt times, then presents the result and the last bit shifted out.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// SHIFT | one step per clock until count reaches zero
// DONE  | result held on out_data/out_carry, out_valid=1
module iter_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input logic           clk,
  input logic           rst_n,
  iter_shifter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;
  logic             accept;

  function automatic logic op_valid(input logic [2:0] op);
    case (op)
      3'b001, 3'b100, 3'b101, 3'b010, 3'b110: op_valid = 1'b1;
      default:                                op_valid = 1'b0;
    endcase
  endfunction

  // Returns {carry, data} after one step of the given opcode.
  function automatic logic [WIDTH:0] step(input logic [2:0] op,
                                          input logic [WIDTH-1:0] w);
    case (op)
      3'b001:  step = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
      3'b100:  step = {w[0], 1'b0, w[WIDTH-1:1]};
      3'b101:  step = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
      3'b010:  step = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
      3'b110:  step = {w[0], w[0], w[WIDTH-1:1]};
      default: step = {1'b0, w};
    endcase
  endfunction

  assign accept = bus.in_valid && (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; invalid opcodes and amt=0 skip straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if ((bus.in_amt != '0) && op_valid(bus.in_op)) state_nxt = SHIFT;
          else                                           state_nxt = DONE;
        end
      end
      SHIFT: begin
        if (count == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and result outputs.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out_data  = data_q;
    bus.out_carry = carry_q;
  end

  // Working value, carry, opcode and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      carry_q <= 1'b0;
      op_q    <= 3'b000;
      count   <= '0;
    end else if (accept) begin
      data_q  <= bus.in_data;
      carry_q <= 1'b0;
      op_q    <= bus.in_op;
      count   <= bus.in_amt;
    end else if (state == SHIFT) begin
      {carry_q, data_q} <= step(op_q, data_q);
      count             <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Randomized bench for iter_shifter against an arithmetic reference model.
module tb_iter_shifter;
  localparam int W  = 8;
  localparam int CW = 3;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  iter_shifter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  iter_shifter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-shift reference: returns {carry, data}.
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [2:0] op, input int amt);
    logic [31:0]  w;
    logic [W-1:0] r;
    logic         c;
    int           k;
    if (amt == 0 || !(op inside {3'b001, 3'b100, 3'b101, 3'b010, 3'b110}))
      return {1'b0, d};
    k = amt % W;
    r = d;
    c = 1'b0;
    case (op)
      3'b001: begin w = {24'b0, d} << amt; r = w[W-1:0]; c = w[W]; end
      3'b100: begin r = d >> amt; c = d[amt-1]; end
      3'b101: begin r = $signed(d) >>> amt; c = d[amt-1]; end
      3'b010: begin r = (d << k) | (d >> (W - k)); c = r[0]; end
      3'b110: begin r = (d >> k) | (d << (W - k)); c = r[W-1]; end
      default: ;
    endcase
    return {c, r};
  endfunction

  // Issue one request, check latency and result; hold DONE for 'hold' cycles.
  task automatic run_txn(input logic [W-1:0] d, input logic [2:0] op, input int amt, input int hold);
    logic [W:0] exp;
    int cyc;
    int exp_lat;
    exp = model(d, op, amt);
    exp_lat = (amt == 0 || !(op inside {3'b001, 3'b100, 3'b101, 3'b010, 3'b110})) ? 1 : 1 + amt;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_op    = op;
    bus.in_amt   = CW'(amt);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("out_data", 32'(bus.out_data), 32'(exp[W-1:0]));
    chk("out_carry", 32'(bus.out_carry), 32'(exp[W]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", 32'(bus.out_data), 32'(exp[W-1:0]));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("ret_idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);
  endtask

  initial begin
    int saw_valid;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = 3'b000;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;

    // Reset values, with a request pending that must not be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    bus.in_op    = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_carry", 32'(bus.out_carry), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    // Directed cases.
    run_txn(8'b10001100, 3'b001, 3, 0);
    run_txn(8'b10001100, 3'b110, 3, 0);
    run_txn(8'b10001100, 3'b101, 2, 0);
    run_txn(8'b10001100, 3'b000, 5, 0);
    run_txn(8'b10001100, 3'b010, 0, 0);
    run_txn(8'b11110000, 3'b100, 7, 0);
    run_txn(8'b10000001, 3'b010, 7, 0);

    // Back-pressure in DONE with in_valid asserted: no second accept.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'b10001100;
    bus.in_op    = 3'b001;
    bus.in_amt   = 3'd1;
    repeat (3) @(negedge clk);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'({bus.out_valid, bus.in_ready, bus.out_carry, bus.out_data}),
          32'({1'b1, 1'b0, 1'b1, 8'b00011000}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp_release", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    @(negedge clk);
    chk("bp_no_second", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    // Reset in the middle of a shift.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'b11011011;
    bus.in_op    = 3'b100;
    bus.in_amt   = 3'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", 32'({bus.out_valid, bus.in_ready, bus.out_carry, bus.out_data}),
        32'({1'b0, 1'b1, 1'b0, 8'h00}));
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1;
    end
    chk("mid_rst_no_result", 32'(saw_valid), 32'd0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      run_txn(W'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
